// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Optional performance counters are enabled with `define INST_FETCH_PERF_CNT_EN.
package inst_fetch_pkg;

   localparam int          FETCH_DATA_W = 32;
   localparam logic [31:0] PC_STEP      = 32'd4;

   typedef enum logic {
      FETCH_IDLE = 1'b0,
      FETCH_RUN  = 1'b1
   } fetch_state_e;

   // One buffered instruction, tagged with the byte PC it was fetched from.
   typedef struct packed {
      logic [31:0]             pc;
      logic [FETCH_DATA_W-1:0] data;
   } fetch_entry_t;

   function automatic logic [31:0] align_pc(input logic [31:0] pc);
      return {pc[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Memory read port and decode handshake of the fetch stage.
// master = fetch unit side, slave = memory/decode side.
interface inst_fetch_if #(
   parameter int ADDR_W = 13,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0] mem_address;
   logic              mem_chipselect;
   logic              mem_write;
   logic [3:0]        mem_byteenable;
   logic              mem_clken;
   logic [DATA_W-1:0] mem_readdata;
   logic              inst_valid;
   logic [DATA_W-1:0] inst_data;
   logic [31:0]       inst_pc;
   logic              inst_ready;

   modport master (
      output mem_address, mem_chipselect, mem_write, mem_byteenable, mem_clken,
      input  mem_readdata,
      output inst_valid, inst_data, inst_pc,
      input  inst_ready
   );

   modport slave (
      input  mem_address, mem_chipselect, mem_write, mem_byteenable, mem_clken,
      output mem_readdata,
      input  inst_valid, inst_data, inst_pc,
      output inst_ready
   );
endinterface

// File: rtl/inst_fetch_fifo.sv
// Shift-register instruction buffer: slot 0 is always the registered head,
// so head data cannot change while it is waiting to be popped.
module inst_fetch_fifo
   import inst_fetch_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  fetch_entry_t     push_data,
   input  logic             pop,
   input  logic             flush,
   output logic [CNT_W-1:0] count,
   output fetch_entry_t     head
);

   fetch_entry_t     entry_q  [DEPTH];
   fetch_entry_t     entry_d  [DEPTH];
   fetch_entry_t     shift_in [DEPTH];
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   logic [CNT_W-1:0] wr_idx;

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_shift
         if (gi < DEPTH - 1) begin : g_next
            assign shift_in[gi] = entry_q[gi + 1];
         end else begin : g_tail
            assign shift_in[gi] = '0;
         end
      end
   endgenerate

   always_comb begin
      // A simultaneous pop shifts everything down, so the write lands one slot lower.
      wr_idx  = count_q - CNT_W'(pop);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      for (int i = 0; i < DEPTH; i++) begin
         entry_d[i] = pop ? shift_in[i] : entry_q[i];
         if (push && !flush && (wr_idx == CNT_W'(i))) begin
            entry_d[i] = push_data;
         end
      end
      if (flush) begin
         count_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            entry_q[i] <= '0;
         end
      end else begin
         count_q <= count_d;
         for (int i = 0; i < DEPTH; i++) begin
            entry_q[i] <= entry_d[i];
         end
      end
   end

   assign count = count_q;
   assign head  = entry_q[0];

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: PC generation, 1-cycle-latency memory reads, buffered
// delivery to decode. `define INST_FETCH_PERF_CNT_EN adds pop/stall counters.
module inst_fetch_unit
   import inst_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          ADDR_W     = 13,
   parameter int          DATA_W     = FETCH_DATA_W,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        fetch_enable,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        align_fault,
`ifdef INST_FETCH_PERF_CNT_EN
   output logic [31:0] perf_fetch_cnt,
   output logic [31:0] perf_stall_cnt,
`endif
   inst_fetch_if.master bus
);

   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   fetch_state_e      fetch_state;
   logic              run;
   logic [31:0]       pc_q, pc_d;
   logic [31:0]       issue_pc_q, issue_pc_d;
   logic              inflight_q, inflight_d;
   logic              align_fault_q, align_fault_d;
   logic [31:0]       fetch_pc;
   logic              issue;
   logic [3:0]        used;
   logic              pop;
   logic              fifo_push;
   logic [CNT_W-1:0]  fifo_count;
   fetch_entry_t      fifo_head;
   fetch_entry_t      fifo_in;
   logic [DATA_W-1:0] rdata;

   assign rdata = bus.mem_readdata;

   always_comb begin
      fetch_state = fetch_enable ? FETCH_RUN : FETCH_IDLE;
      run         = (fetch_state == FETCH_RUN);
      pop         = (fifo_count != '0) && bus.inst_ready;
      // Slots already claimed after this cycle's pop: buffered plus the read in flight.
      used        = 4'(fifo_count) + 4'(inflight_q) - 4'(pop);
      issue       = 1'b0;
      fetch_pc    = pc_q;
      pc_d        = pc_q;
      if (redirect_valid) begin
         fetch_pc = align_pc(redirect_pc);
         pc_d     = align_pc(redirect_pc);
         if (run) begin
            issue = 1'b1;
            pc_d  = align_pc(redirect_pc) + PC_STEP;
         end
      end else if (run && (used < 4'(FIFO_DEPTH))) begin
         issue = 1'b1;
         pc_d  = pc_q + PC_STEP;
      end
      inflight_d    = issue;
      issue_pc_d    = issue ? fetch_pc : issue_pc_q;
      fifo_push     = inflight_q && !redirect_valid;
      fifo_in.pc    = issue_pc_q;
      fifo_in.data  = rdata;
      align_fault_d = align_fault_q | (redirect_valid && (redirect_pc[1:0] != 2'b00));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q          <= RESET_PC;
         issue_pc_q    <= '0;
         inflight_q    <= 1'b0;
         align_fault_q <= 1'b0;
      end else begin
         pc_q          <= pc_d;
         issue_pc_q    <= issue_pc_d;
         inflight_q    <= inflight_d;
         align_fault_q <= align_fault_d;
      end
   end

   inst_fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (fifo_push),
      .push_data (fifo_in),
      .pop       (pop),
      .flush     (redirect_valid),
      .count     (fifo_count),
      .head      (fifo_head)
   );

   assign bus.mem_address    = reset ? '0 : fetch_pc[ADDR_W+1:2];
   assign bus.mem_chipselect = issue && !reset;
   assign bus.mem_write      = 1'b0;
   assign bus.mem_byteenable = 4'hF;
   assign bus.mem_clken      = !reset;
   assign bus.inst_valid     = (fifo_count != '0);
   assign bus.inst_data      = fifo_head.data;
   assign bus.inst_pc        = fifo_head.pc;
   assign align_fault        = align_fault_q;

`ifdef INST_FETCH_PERF_CNT_EN
   logic [31:0] perf_fetch_q, perf_fetch_d;
   logic [31:0] perf_stall_q, perf_stall_d;

   always_comb begin
      perf_fetch_d = perf_fetch_q + 32'(pop);
      perf_stall_d = perf_stall_q + 32'((fifo_count != '0) && !bus.inst_ready);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         perf_fetch_q <= '0;
         perf_stall_q <= '0;
      end else begin
         perf_fetch_q <= perf_fetch_d;
         perf_stall_q <= perf_stall_d;
      end
   end

   assign perf_fetch_cnt = perf_fetch_q;
   assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Scoreboard bench for inst_fetch_unit: stimulus pushes expected {pc,data},
// a negedge monitor pops and compares on every decode handshake.
module tb_inst_fetch_unit;

   localparam int FIFO_DEPTH = 2;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] data;
   } exp_t;

   logic        clk;
   logic        reset;
   logic        fetch_enable;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        align_fault;
`ifdef INST_FETCH_PERF_CNT_EN
   logic [31:0] perf_fetch_cnt;
   logic [31:0] perf_stall_cnt;
`endif

   exp_t exp_q[$];
   int   n_tests;
   int   n_fail;
   int   n_pop;
   int   n_pop_rst;
   int   n_stall_rst;
   logic overflow_seen;

   inst_fetch_if #(.ADDR_W(13), .DATA_W(32)) bus ();

   inst_fetch_unit #(
      .RESET_PC   (32'h0000_0000),
      .ADDR_W     (13),
      .DATA_W     (32),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .fetch_enable   (fetch_enable),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .align_fault    (align_fault),
`ifdef INST_FETCH_PERF_CNT_EN
      .perf_fetch_cnt (perf_fetch_cnt),
      .perf_stall_cnt (perf_stall_cnt),
`endif
      .bus            (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory: word k holds A000_0000 + k, one-cycle read latency.
   always @(posedge clk) begin
      if (bus.mem_chipselect) begin
         bus.mem_readdata <= 32'hA000_0000 + 32'(bus.mem_address);
      end
   end

   function automatic logic [31:0] word_of(input logic [31:0] pc);
      return 32'hA000_0000 + ((pc >> 2) & 32'h0000_1FFF);
   endfunction

   task automatic push_stream(input logic [31:0] start_pc, input int n);
      exp_t e;
      exp_q.delete();
      for (int i = 0; i < n; i++) begin
         e.pc   = start_pc + 32'(4 * i);
         e.data = word_of(e.pc);
         exp_q.push_back(e);
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h, required %h", name, act, req);
      end else begin
         $display("[TB] ok   %s: %h", name, act);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Monitor: one line per delivered instruction.
   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         n_pop_rst   = 0;
         n_stall_rst = 0;
      end else begin
         if (bus.inst_valid && !bus.inst_ready) n_stall_rst++;
         if (bus.inst_valid && bus.inst_ready) begin
            n_pop++;
            n_pop_rst++;
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("[TB] FAIL deliver: got pc=%h data=%h, required no delivery", bus.inst_pc, bus.inst_data);
            end else begin
               e = exp_q.pop_front();
               if (bus.inst_pc !== e.pc || bus.inst_data !== e.data) begin
                  n_fail++;
                  $display("[TB] FAIL deliver: got pc=%h data=%h, required pc=%h data=%h",
                           bus.inst_pc, bus.inst_data, e.pc, e.data);
               end else begin
                  $display("[TB] ok   deliver pc=%h data=%h", e.pc, e.data);
               end
            end
         end
      end
      if (dut.fifo_push && !dut.redirect_valid && !reset &&
          (int'(dut.fifo_count) - int'(dut.pop) >= FIFO_DEPTH)) begin
         overflow_seen = 1'b1;
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int p0;
      n_tests = 0; n_fail = 0; n_pop = 0; n_pop_rst = 0; n_stall_rst = 0;
      overflow_seen = 1'b0;
      reset = 1'b1; fetch_enable = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      bus.inst_ready = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #2;
      check("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
      check("rst_inst_pc", bus.inst_pc, 32'd0);
      check("rst_inst_data", bus.inst_data, 32'd0);
      check("rst_chipselect", 32'(bus.mem_chipselect), 32'd0);
      check("rst_clken", 32'(bus.mem_clken), 32'd0);
      check("rst_address", 32'(bus.mem_address), 32'd0);
      check("rst_align_fault", 32'(align_fault), 32'd0);
      check("mem_write", 32'(bus.mem_write), 32'd0);
      check("mem_byteenable", 32'(bus.mem_byteenable), 32'hF);

      // Release: first instruction valid 2 cycles later, then one per cycle
      cyc();
      reset = 1'b0; fetch_enable = 1'b1; bus.inst_ready = 1'b1;
      push_stream(32'h0, 64);
      #1;
      check("rel_chipselect", 32'(bus.mem_chipselect), 32'd1);
      check("rel_address", 32'(bus.mem_address), 32'd0);
      check("rel_clken", 32'(bus.mem_clken), 32'd1);
      check("rel_valid_c0", 32'(bus.inst_valid), 32'd0);
      cyc(); #1;
      check("rel_valid_c1", 32'(bus.inst_valid), 32'd0);
      check("rel_address_c1", 32'(bus.mem_address), 32'd1);
      cyc(); #1;
      check("rel_valid_c2", 32'(bus.inst_valid), 32'd1);
      check("rel_pc_c2", bus.inst_pc, 32'h0);
      check("rel_data_c2", bus.inst_data, 32'hA000_0000);
      p0 = n_pop;
      repeat (10) cyc();
      check("throughput_10", 32'(n_pop - p0), 32'd10);

      // Back-pressure: head held, no new issue once buffer is full
      bus.inst_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         #1;
         check("stall_valid", 32'(bus.inst_valid), 32'd1);
         check("stall_pc", bus.inst_pc, (exp_q.size() != 0) ? exp_q[0].pc : 32'hDEAD_BEEF);
         check("stall_data", bus.inst_data, (exp_q.size() != 0) ? exp_q[0].data : 32'hDEAD_BEEF);
         check("stall_no_issue", 32'(bus.mem_chipselect), 32'd0);
         cyc();
      end
      bus.inst_ready = 1'b1;
      repeat (4) cyc();
      bus.inst_ready = 1'b0;
      repeat (2) cyc();

      // Redirect with a full buffer
      #1;
      check("full_before_redirect", 32'(bus.inst_valid), 32'd1);
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
      #1;
      check("redir_chipselect", 32'(bus.mem_chipselect), 32'd1);
      check("redir_address", 32'(bus.mem_address), 32'd64);
      cyc();
      redirect_valid = 1'b0; bus.inst_ready = 1'b1;
      push_stream(32'h0000_0100, 64);
      #1;
      check("redir_valid_d1", 32'(bus.inst_valid), 32'd0);
      cyc(); #1;
      check("redir_valid_d2", 32'(bus.inst_valid), 32'd1);
      check("redir_pc_d2", bus.inst_pc, 32'h0000_0100);
      check("redir_data_d2", bus.inst_data, 32'hA000_0040);
      repeat (3) cyc();

      // Redirect to the last memory word: index wraps, PC does not
      redirect_valid = 1'b1; redirect_pc = 32'h0000_7FFC;
      #1;
      check("wrap_address_d0", 32'(bus.mem_address), 32'h1FFF);
      cyc();
      redirect_valid = 1'b0;
      push_stream(32'h0000_7FFC, 64);
      #1;
      check("wrap_address_d1", 32'(bus.mem_address), 32'h0);
      check("wrap_valid_d1", 32'(bus.inst_valid), 32'd0);
      cyc(); #1;
      check("wrap_pc_a", bus.inst_pc, 32'h0000_7FFC);
      check("wrap_data_a", bus.inst_data, 32'hA000_1FFF);
      cyc(); #1;
      check("wrap_pc_b", bus.inst_pc, 32'h0000_8000);
      check("wrap_data_b", bus.inst_data, 32'hA000_0000);
      check("aligned_no_fault", 32'(align_fault), 32'd0);
      repeat (2) cyc();

      // Back-to-back redirects, the second misaligned
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
      cyc();
      redirect_pc = 32'h0000_0102;
      #1;
      check("b2b_fault_before", 32'(align_fault), 32'd0);
      check("b2b_address", 32'(bus.mem_address), 32'd64);
      cyc();
      redirect_valid = 1'b0;
      push_stream(32'h0000_0100, 64);
      #1;
      check("misalign_fault", 32'(align_fault), 32'd1);
      check("b2b_valid_d1", 32'(bus.inst_valid), 32'd0);
      cyc(); #1;
      check("b2b_pc_d2", bus.inst_pc, 32'h0000_0100);
      check("b2b_data_d2", bus.inst_data, 32'hA000_0040);
      repeat (4) cyc();
      check("fault_sticky", 32'(align_fault), 32'd1);

      // Fetch disable: no issue, buffer drains normally
      fetch_enable = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         check("disabled_no_issue", 32'(bus.mem_chipselect), 32'd0);
         cyc();
      end
      check("drained_valid", 32'(bus.inst_valid), 32'd0);

      // Reset with a read in flight and an entry buffered
      fetch_enable = 1'b1; bus.inst_ready = 1'b0;
      #1;
      check("reenable_issue", 32'(bus.mem_chipselect), 32'd1);
      cyc();
      cyc();
      reset = 1'b1; fetch_enable = 1'b0;
      #1;
      check("midrst_chipselect", 32'(bus.mem_chipselect), 32'd0);
      check("midrst_clken", 32'(bus.mem_clken), 32'd0);
      cyc();
      reset = 1'b0; fetch_enable = 1'b1; bus.inst_ready = 1'b1;
      push_stream(32'h0, 64);
      #1;
      check("postrst_valid", 32'(bus.inst_valid), 32'd0);
      check("postrst_pc", bus.inst_pc, 32'd0);
      check("postrst_data", bus.inst_data, 32'd0);
      check("postrst_fault", 32'(align_fault), 32'd0);
      check("postrst_address", 32'(bus.mem_address), 32'd0);
      check("postrst_chipselect", 32'(bus.mem_chipselect), 32'd1);
      cyc(); #1;
      check("postrst_valid_c1", 32'(bus.inst_valid), 32'd0);
      cyc(); #1;
      check("postrst_valid_c2", 32'(bus.inst_valid), 32'd1);
      check("postrst_pc_c2", bus.inst_pc, 32'h0);
      check("postrst_data_c2", bus.inst_data, 32'hA000_0000);
      repeat (6) cyc();

`ifdef INST_FETCH_PERF_CNT_EN
      check("perf_fetch_cnt", perf_fetch_cnt, 32'(n_pop_rst));
      check("perf_stall_cnt", perf_stall_cnt, 32'(n_stall_rst));
`endif
      check("fifo_no_overflow", 32'(overflow_seen), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Instruction fetch stage that sits directly upstream of the 8192x32 single-port instruction memory.
- Generates the byte PC and drives word reads into the memory's Avalon-style slave port.
- Captures the 1-cycle-latency read data into a small FIFO and presents instructions to decode with a valid/ready handshake.
- Handles redirects (branch/jump/exception), fetch enable and back-pressure.

Parameters:
- RESET_PC, 32'h0000_0000, byte PC fetched first after reset; must be word aligned.
- ADDR_W, 13, memory word-address width (8192 words).
- DATA_W, 32, instruction width.
- FIFO_DEPTH, 2, instruction buffer entries; legal values 2 and 4.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- fetch_enable  in  1  1 = issue fetches; 0 = stop issuing new fetches.
- mem_address  out  ADDR_W  word address, equal to pc[ADDR_W+1:2].
- mem_chipselect  out  1  read strobe, valid for one cycle per issued fetch.
- mem_write  out  1  tied 0.
- mem_byteenable  out  4  tied 4'hF.
- mem_clken  out  1  0 during reset, 1 otherwise.
- mem_readdata  in  DATA_W  data for the fetch issued in the previous cycle.
- redirect_valid  in  1  one-cycle pulse that loads redirect_pc.
- redirect_pc  in  32  new byte PC.
- inst_valid  out  1  FIFO head holds a valid instruction.
- inst_data  out  DATA_W  FIFO head instruction.
- inst_pc  out  32  byte PC of inst_data.
- inst_ready  in  1  decode accepts the head; a pop occurs when inst_valid & inst_ready.
- align_fault  out  1  sticky; set when a redirect_pc is misaligned.

Behaviour:
- Reset (synchronous, active-high):
  - pc=RESET_PC, FIFO count=0, inflight=0, align_fault=0.
  - inst_valid=0, inst_data=0, inst_pc=0, mem_chipselect=0, mem_address=0, mem_clken=0.
  - Asserting reset mid-operation clears all of the above at that edge; any in-flight response is discarded.
- States:
  - IDLE: after reset, or while fetch_enable=0.
  - RUN: entered in the first cycle with reset=0 and fetch_enable=1.
  - RUN->IDLE when fetch_enable=0. The in-flight response still completes; FIFO contents are retained and drained normally.
- Issue (RUN only):
  - credits = FIFO_DEPTH - count - inflight + pop.
  - Issue when credits>0: mem_chipselect=1, then pc += 4 and inflight=1 next cycle; otherwise inflight=0.
  - Steady-state throughput is 1 instruction per cycle when inst_ready stays at 1.
- Response:
  - Issue in cycle N means mem_readdata is valid in cycle N+1 and is pushed at the end of N+1, paired with its PC.
  - inst_valid goes high in N+2. Issue-to-valid latency is 2 cycles.
  - The first instruction after reset release is valid in the 2nd cycle after release.
- FIFO:
  - Registered head; inst_valid = (count != 0).
  - Push and pop in the same cycle leave count unchanged.
  - Push into a full FIFO is impossible by construction; the bench asserts this never happens.
  - Head data is held stable while inst_valid=1 and inst_ready=0.
- Redirect (priority over everything except reset):
  - A pop in the same cycle completes normally.
  - Then count:=0, and the response arriving this cycle is dropped.
  - A fetch is issued this cycle at redirect_pc, regardless of credits, provided state is RUN; pc:=redirect_pc+4.
  - In IDLE: pc:=redirect_pc and no issue.
  - inst_valid=0 next cycle; first redirected instruction is valid 2 cycles after the redirect.
  - Back-to-back redirects: the last one wins.
  - If redirect_pc[1:0] != 0: align_fault:=1, and the address is forced aligned (low bits cleared).
- PC arithmetic:
  - 32-bit, wraps at 2^32.
  - Memory index uses pc[ADDR_W+1:2] only, so word address 8191 wraps to 0; inst_pc still reports the full PC.

Optional Feature:
- Macro: INST_FETCH_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_fetch_cnt[31:0] (increments on each pop) and perf_stall_cnt[31:0] (increments each cycle with inst_valid & ~inst_ready).
  - Both clear on reset and wrap at 2^32.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package inst_fetch_pkg:
  - FETCH_IDLE/FETCH_RUN state enum.
  - PC_STEP=4.
  - fetch_entry_t struct {pc[31:0], data[DATA_W-1:0]}.
- One sub-module: inst_fetch_fifo, a parameterized synchronous FIFO holding fetch_entry_t, with push/pop/flush and count output.

Test Plan:
- Reset release, memory word k = 32'hA000_0000+k, inst_ready=1 -> inst_valid high 2 cycles after release; inst_pc sequence 0,4,8,... with data A0000000, A0000001, ... at one per cycle.
- inst_ready=0 for 5 cycles in steady run -> at most FIFO_DEPTH entries buffered; head data/pc stable; after release, no lost or duplicated PCs.
- redirect_valid with redirect_pc=32'h0000_0100 while FIFO full -> inst_valid=0 next cycle; next delivered inst_pc=0x100, data=word 64; stale entries never appear.
- Redirect to 32'h0000_7FFC (word 8191) -> inst_pc 0x7FFC then 0x8000; second instruction read from word address 0.
- redirect_pc=32'h0000_0102 -> align_fault=1 (sticky); fetch from 0x100; a subsequent reset clears align_fault.
- fetch_enable low mid-run, then reset pulse while an access is in flight -> no issue after enable drops; reset clears inst_valid and count; fetch restarts at RESET_PC.
